// File: rtl/text_vram_if.sv
`default_nettype none
// ============================================================================
// Module   : text_vram_if
// Purpose  : Writer character stream and display-timing bus for text_vram_ctrl.
//            master = writer/display side, slave = the VRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
interface text_vram_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic [9:0] h_addr;
  logic [9:0] v_addr;
  logic [7:0] ascii_out;
  logic [3:0] glyph_x;
  logic [3:0] glyph_y;
  logic       cursor_hit;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic       busy;

  modport master (
    output char_valid, char_data, h_addr, v_addr,
    input  char_ready, ascii_out, glyph_x, glyph_y, cursor_hit,
           cursor_col, cursor_row, busy
  );

  modport slave (
    input  char_valid, char_data, h_addr, v_addr,
    output char_ready, ascii_out, glyph_x, glyph_y, cursor_hit,
           cursor_col, cursor_row, busy
  );
endinterface
`default_nettype wire

// File: rtl/text_vram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_vram_ctrl
// Purpose  : Text-mode video RAM with a terminal-style character writer
//            (cursor, newline, backspace, form-feed clear, scroll) and a
//            registered pixel-to-cell display lookup.
// Options  : TEXT_VRAM_CURSOR_EN - build the blinking cursor overlay;
//            when undefined, cursor_hit is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module text_vram_ctrl #(
  parameter int COLS         = 70,
  parameter int ROWS         = 30,
  parameter int CHAR_W       = 9,
  parameter int CHAR_H       = 16,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        resetn,
  text_vram_if.slave  bus
);

  localparam int CELLS         = COLS * ROWS;
  localparam int AW            = $clog2(CELLS);
  localparam int SCROLL_LEN    = COLS * (ROWS - 1);
  localparam int LAST_ROW_BASE = (ROWS - 1) * COLS;

  typedef enum logic [1:0] {IDLE, SCROLL, CLR_ROW, CLR_ALL} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [6:0]    col, col_nxt;
  logic [5:0]    row, row_nxt;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [AW-1:0] cur_addr;
  logic [7:0]    mem [CELLS];

  assign cur_addr = AW'(int'(row) * COLS + int'(col));

  // State, sweep index and cursor registers; reset starts a full-screen clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= CLR_ALL;
      idx   <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Next-state, cursor movement and the single memory write port.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    col_nxt   = col;
    row_nxt   = row;
    we        = 1'b0;
    waddr     = idx;
    wdata     = 8'h20;
    case (state)
      IDLE: begin
        if (bus.char_valid) begin
          if (bus.char_data >= 8'h20 && bus.char_data <= 8'h7E) begin
            we    = 1'b1;
            waddr = cur_addr;
            wdata = bus.char_data;
            if (col == 7'(COLS - 1)) begin
              col_nxt = '0;
              if (row == 6'(ROWS - 1)) begin
                state_nxt = SCROLL;
                idx_nxt   = '0;
              end else begin
                row_nxt = row + 6'd1;
              end
            end else begin
              col_nxt = col + 7'd1;
            end
          end else if (bus.char_data == 8'h0A || bus.char_data == 8'h0D) begin
            col_nxt = '0;
            if (row == 6'(ROWS - 1)) begin
              state_nxt = SCROLL;
              idx_nxt   = '0;
            end else begin
              row_nxt = row + 6'd1;
            end
          end else if (bus.char_data == 8'h08) begin
            // Backspace never wraps to the previous row.
            if (col != 7'd0) begin
              col_nxt = col - 7'd1;
              we      = 1'b1;
              waddr   = cur_addr - AW'(1);
            end
          end else if (bus.char_data == 8'h0C) begin
            col_nxt   = '0;
            row_nxt   = '0;
            state_nxt = CLR_ALL;
            idx_nxt   = '0;
          end
        end
      end
      SCROLL: begin
        we    = 1'b1;
        waddr = idx;
        wdata = mem[idx + AW'(COLS)];
        if (idx == AW'(SCROLL_LEN - 1)) begin
          state_nxt = CLR_ROW;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
      CLR_ROW: begin
        we    = 1'b1;
        waddr = AW'(LAST_ROW_BASE) + idx;
        if (idx == AW'(COLS - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
      default: begin  // CLR_ALL
        we    = 1'b1;
        waddr = idx;
        if (idx == AW'(CELLS - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
    endcase
  end

  // Cell storage is never reset; the clear sweep blanks it after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Display lookup: pixel address to cell index, read never stalls.
  logic [9:0]    col_idx, row_idx;
  logic          in_range;
  logic [AW-1:0] rd_addr;
  logic [7:0]    ascii_q;
  logic [3:0]    gx_q, gy_q;

  assign col_idx  = 10'(int'(bus.h_addr) / CHAR_W);
  assign row_idx  = 10'(int'(bus.v_addr) / CHAR_H);
  assign in_range = (int'(col_idx) < COLS) && (int'(row_idx) < ROWS);
  assign rd_addr  = in_range ? AW'(int'(row_idx) * COLS + int'(col_idx)) : '0;

  // Registered display outputs, one cycle after the pixel address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ascii_q <= 8'h00;
      gx_q    <= '0;
      gy_q    <= '0;
    end else begin
      ascii_q <= in_range ? mem[rd_addr] : 8'h20;
      gx_q    <= 4'(int'(bus.h_addr) % CHAR_W);
      gy_q    <= 4'(int'(bus.v_addr) % CHAR_H);
    end
  end

`ifdef TEXT_VRAM_CURSOR_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          hit_q;

  // Blink half-period counter; phase starts visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Cursor overlay is hidden while a sweep owns the memory.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hit_q <= 1'b0;
    else         hit_q <= phase && (row_idx == {4'b0, row}) &&
                          (col_idx == {3'b0, col}) && (state == IDLE);
  end

  assign bus.cursor_hit = hit_q;
`else
  assign bus.cursor_hit = 1'b0;
`endif

  assign bus.char_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.ascii_out  = ascii_q;
  assign bus.glyph_x    = gx_q;
  assign bus.glyph_y    = gy_q;
  assign bus.cursor_col = col;
  assign bus.cursor_row = row;

endmodule
`default_nettype wire

// File: tb/tb_text_vram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_vram_ctrl
// Purpose  : Self-checking bench for text_vram_ctrl against a screen/cursor
//            reference model held as a plain byte array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_vram_ctrl;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CW    = 9;
  localparam int CH    = 16;
  localparam int CELLS = COLS * ROWS;
  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  text_vram_if bus();

  text_vram_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .CHAR_H(CH), .BLINK_CYCLES(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  logic [7:0] model [CELLS];
  int m_col, m_row;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) model[i] = 8'h20;
    m_col = 0;
    m_row = 0;
  endtask

  // Move down one row; on the bottom row the whole screen shifts up.
  task automatic model_newline(output int stall);
    stall = 0;
    if (m_row == ROWS - 1) begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          model[r * COLS + c] = model[(r + 1) * COLS + c];
      for (int c = 0; c < COLS; c++) model[(ROWS - 1) * COLS + c] = 8'h20;
      stall = COLS * (ROWS - 1) + COLS;
    end else begin
      m_row++;
    end
  endtask

  task automatic model_apply(input logic [7:0] ch, output int stall);
    stall = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      model[m_row * COLS + m_col] = ch;
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_newline(stall);
      end else begin
        m_col++;
      end
    end else if (ch == 8'h0A || ch == 8'h0D) begin
      m_col = 0;
      model_newline(stall);
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        model[m_row * COLS + m_col] = 8'h20;
      end
    end else if (ch == 8'h0C) begin
      model_clear();
      stall = COLS * ROWS;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one character, then check the stall length and the cursor.
  task automatic send(input logic [7:0] ch);
    int n, stall;
    n = 0;
    while (!bus.char_ready && n < LIMIT) begin tick(); n++; end
    check("ready_wait", 32'(n < LIMIT), 1);
    bus.char_valid = 1'b1;
    bus.char_data  = ch;
    tick();
    bus.char_valid = 1'b0;
    bus.char_data  = $urandom_range(0, 255);
    model_apply(ch, stall);
    n = 0;
    while (!bus.char_ready && n < LIMIT) begin tick(); n++; end
    check("stall_len", n, stall);
    check("cursor_col", 32'(bus.cursor_col), m_col);
    check("cursor_row", 32'(bus.cursor_row), m_row);
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    bus.h_addr = 10'(c * CW + $urandom_range(0, CW - 1));
    bus.v_addr = 10'(r * CH + $urandom_range(0, CH - 1));
    tick();
    v = bus.ascii_out;
  endtask

  task automatic check_screen(input string tag);
    int bad;
    logic [7:0] v;
    bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        if (v !== model[r * COLS + c]) bad++;
      end
    check(tag, bad, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ones, pick;
    logic [7:0] v, ch;
    logic s [17];

    resetn         = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.h_addr     = 10'd0;
    bus.v_addr     = 10'd0;
    repeat (3) tick();

    check("rst_busy", 32'(bus.busy), 1);
    check("rst_ready", 32'(bus.char_ready), 0);
    check("rst_ascii", 32'(bus.ascii_out), 0);
    check("rst_glyph", 32'({bus.glyph_x, bus.glyph_y}), 0);
    check("rst_hit", 32'(bus.cursor_hit), 0);
    check("rst_cursor", 32'({bus.cursor_col, bus.cursor_row}), 0);

    resetn = 1'b1;
    n = 0;
    while (bus.busy && n < LIMIT) begin tick(); n++; end
    check("init_clear_len", n, CELLS);
    model_clear();
    check_screen("init_screen");

    // Single character then a glyph-column sweep over its cell.
    send(8'h41);
    for (int x = 0; x < CW; x++) begin
      bus.h_addr = 10'(x);
      bus.v_addr = 10'd0;
      tick();
      check("a_ascii", 32'(bus.ascii_out), 32'h41);
      check("a_glyph_x", 32'(bus.glyph_x), x);
    end
    bus.h_addr = 10'd1023; bus.v_addr = 10'd37; tick();
    check("oob_col", 32'(bus.ascii_out), 32'h20);
    check("oob_gx", 32'(bus.glyph_x), 1023 % CW);
    check("oob_gy", 32'(bus.glyph_y), 37 % CH);
    bus.h_addr = 10'd0; bus.v_addr = 10'(ROWS * CH); tick();
    check("oob_row", 32'(bus.ascii_out), 32'h20);

    // Full row wraps to the next row.
    send(8'h0C);
    for (int i = 0; i < COLS; i++) send(8'h42);
    check("wrap_cursor", 32'({bus.cursor_col, bus.cursor_row}), 32'({7'd0, 6'd1}));
    send(8'h43);
    read_cell(1, 0, v);  check("wrap_71st", 32'(v), 32'h43);
    read_cell(0, 69, v); check("wrap_70th", 32'(v), 32'h42);

    // Backspace at column 0 and mid-row.
    send(8'h0D);
    send(8'h08);
    send(8'h78); send(8'h79); send(8'h7A);
    send(8'h08);
    read_cell(m_row, 2, v); check("bs_cell", 32'(v), 32'h20);
    read_cell(m_row, 1, v); check("bs_keep", 32'(v), 32'h79);

    // Cursor overlay on and off the cursor cell.
    bus.h_addr = 10'(m_col * CW + 2);
    bus.v_addr = 10'(m_row * CH + 3);
    tick();
    for (int i = 0; i < 17; i++) begin tick(); s[i] = bus.cursor_hit; end
`ifdef TEXT_VRAM_CURSOR_EN
    for (int i = 0; i < 13; i++) check("blink_toggle", 32'(s[i + 4]), 32'(!s[i]));
`else
    ones = 0;
    for (int i = 0; i < 17; i++) if (s[i]) ones++;
    check("hit_tied_low", ones, 0);
`endif
    bus.h_addr = 10'(((m_col + 5) % COLS) * CW);
    tick();
    ones = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.cursor_hit) ones++; end
    check("hit_off_cursor", ones, 0);

    // Scroll from the bottom row with a random row 1.
    send(8'h0C);
    send(8'h0A);
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32'h20, 32'h7E)));
    while (m_row < ROWS - 1) send(8'h0A);
    send(8'h0A);
    check_screen("scroll_screen");

    // Random character stream.
    send(8'h0C);
    for (int k = 0; k < 150; k++) begin
      pick = $urandom_range(0, 99);
      if (pick < 62)      ch = 8'($urandom_range(32'h20, 32'h7E));
      else if (pick < 76) ch = 8'h0A;
      else if (pick < 82) ch = 8'h0D;
      else if (pick < 90) ch = 8'h08;
      else if (pick < 99) begin
        ch = 8'($urandom_range(0, 255));
        for (int t = 0; t < 50 && ((ch >= 8'h20 && ch <= 8'h7E) || ch == 8'h0A ||
             ch == 8'h0D || ch == 8'h08 || ch == 8'h0C); t++)
          ch = 8'($urandom_range(0, 255));
      end
      else ch = 8'h0C;
      send(ch);
    end
    check_screen("random_screen");

    // Reset in the middle of a scroll.
    while (m_row < ROWS - 1) send(8'h0A);
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h0A;
    tick();
    bus.char_valid = 1'b0;
    repeat (500) tick();
    check("mid_scroll_busy", 32'(bus.busy), 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_cursor", 32'({bus.cursor_col, bus.cursor_row}), 0);
    check("mid_rst_ready", 32'(bus.char_ready), 0);
    tick();
    resetn = 1'b1;
    n = 0;
    while (bus.busy && n < LIMIT) begin tick(); n++; end
    check("rerst_clear_len", n, CELLS);
    model_clear();
    check_screen("rerst_screen");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/text_vram_ctrl.md
TEXT_VRAM_CTRL -- requirements
Module: text_vram_ctrl

Interface
REQ-001 COLS, 70, character columns per screen (1..128).
REQ-002 ROWS, 30, character rows per screen (2..64).
REQ-003 CHAR_W, 9, glyph cell width in pixels (1..16).
REQ-004 CHAR_H, 16, glyph cell height in pixels (1..16).
REQ-005 BLINK_CYCLES, 25000000, clk cycles per cursor blink half-period.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 resetn  in  1  reset; asynchronous, active-low.
REQ-008 char_valid  in  1  writer presents char_data.
REQ-009 char_data  in  8  ASCII code.
REQ-010 char_ready  out  1  block accepts a character this cycle.
REQ-011 h_addr  in  10  pixel column from display timing.
REQ-012 v_addr  in  10  pixel row from display timing.
REQ-013 ascii_out  out  8  code of the cell under (h_addr, v_addr); registered.
REQ-014 glyph_x  out  4  pixel column within the cell; registered.
REQ-015 glyph_y  out  4  pixel row within the cell; registered.
REQ-016 cursor_hit  out  1  pixel lies in the visible cursor cell; registered.
REQ-017 cursor_col  out  7  current cursor column.
REQ-018 cursor_row  out  6  current cursor row.
REQ-019 busy  out  1  FSM not in IDLE.

Function
REQ-020 Storage SHALL be COLS*ROWS bytes; cell index = row*COLS + col.
REQ-021 A transfer SHALL occur on a rising edge with char_valid && char_ready; char_ready = (state == IDLE), independent of char_valid.
REQ-022 FSM states SHALL be IDLE, SCROLL, CLR_ROW, CLR_ALL.
REQ-023 Codes 0x20..0x7E: write at cursor; col+1; at col COLS-1: col=0, row+1; at row ROWS-1, row stays and FSM enters SCROLL.
REQ-024 0x0A or 0x0D: col=0; row+1, or SCROLL when row = ROWS-1.
REQ-025 0x08: at col>0, col-1 and the new cursor cell is written 0x20; at col 0, no action (no reverse wrap).
REQ-026 0x0C: cursor to (0,0); enter CLR_ALL.
REQ-027 All other codes are accepted and discarded, with no state change.
REQ-028 SCROLL copies cell i+COLS into cell i for i = 0..COLS*(ROWS-1)-1, one cell per cycle, in exactly COLS*(ROWS-1) cycles, then enters CLR_ROW.
REQ-029 CLR_ROW writes 0x20 to every cell of row ROWS-1 in exactly COLS cycles, then enters IDLE.
REQ-030 CLR_ALL writes 0x20 to every cell in exactly COLS*ROWS cycles, then enters IDLE.
REQ-031 Display path: col_idx = h_addr / CHAR_W, row_idx = v_addr / CHAR_H, glyph_x = h_addr % CHAR_W, glyph_y = v_addr % CHAR_H; outputs appear 1 cycle after the address.
REQ-032 If col_idx >= COLS or row_idx >= ROWS, ascii_out SHALL be 0x20.
REQ-033 The display path never stalls; reads during SCROLL, CLR_ROW or CLR_ALL return current, partially updated contents.
REQ-034 cursor_col SHALL never exceed COLS-1, and cursor_row SHALL never exceed ROWS-1.

Reset
REQ-035 While resetn is low: ascii_out 0x00, glyph_x/glyph_y 0, cursor_hit 0, cursor (0,0), state CLR_ALL with clear index 0, busy 1, char_ready 0, blink counter 0, blink phase visible.
REQ-036 Cell memory SHALL NOT be reset directly; CLR_ALL blanks it in COLS*ROWS cycles after resetn rises.
REQ-037 Reset asserted mid-SCROLL or mid-CLR SHALL abort the operation and restart CLR_ALL on release.

Configuration
REQ-038 TEXT_VRAM_CURSOR_EN defined: the blink counter toggles phase every BLINK_CYCLES cycles, and cursor_hit = phase && (row_idx, col_idx) == cursor && !busy.
REQ-039 TEXT_VRAM_CURSOR_EN undefined: no blink counter is built, and cursor_hit is tied to 0.

Verification
REQ-040 Release reset with char_valid=0 -> busy high for exactly 2100 cycles, then every cell reads 0x20.
REQ-041 Write 0x41 at (0,0) -> cursor (1,0); h_addr 0..8, v_addr 0 -> ascii_out 0x41 one cycle later, glyph_x 0..8.
REQ-042 Write 70 x 0x42 -> cursor (0,1); the 71st character lands at row 1, col 0.
REQ-043 Cursor on row 29, send 0x0A -> char_ready low for 2030+70 = 2100 cycles; old row 1 appears in row 0, row 29 is all 0x20, cursor is (0,29).
REQ-044 0x08 at col 0 -> no change; 0x08 at col 3 -> col 2 and that cell reads 0x20.
REQ-045 TEXT_VRAM_CURSOR_EN with BLINK_CYCLES=4 -> cursor_hit at the cursor cell toggles every 4 cycles; without the macro, cursor_hit is constant 0.
